// File: rtl/reg_mailbox_responder.sv
// Register-bus mailbox: software-written TX FIFO drained by a hardware consumer, hardware-filled
// RX FIFO popped by software, and a registered level interrupt on FIFO occupancy.

package reg_mailbox_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;
endpackage

module reg_mailbox_responder
    import reg_mailbox_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  reg_req_t          reg_req_i,
    output reg_rsp_t          reg_rsp_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              intr_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, RESP} state_t;

    state_t            state_q;
    reg_rsp_t          rsp_q;
    logic [DATA_W-1:0] txMem_q [DEPTH];
    logic [DATA_W-1:0] rxMem_q [DEPTH];
    logic [AW-1:0]     txWptr_q, txWptr_d, txRptr_q, txRptr_d;
    logic [AW-1:0]     rxWptr_q, rxWptr_d, rxRptr_q, rxRptr_d;
    logic [CW-1:0]     txCount_q, txCount_d, rxCount_q, rxCount_d;
    logic [1:0]        irqEn_q, irqEn_d;
    logic              intr_q, intr_d;

    logic              access, txFull, txEmpty, rxFull, rxEmpty;
    logic [4:0]        offset;
    logic              busTxPush, busRxPop, hwTxPop, hwRxPush, flushTx, flushRx;
    logic [31:0]       accRdata, status;
    logic              accError;
    logic              unusedBits;

    assign txFull  = (txCount_q == FULL);
    assign txEmpty = (txCount_q == '0);
    assign rxFull  = (rxCount_q == FULL);
    assign rxEmpty = (rxCount_q == '0);
    assign access  = (state_q == IDLE) && reg_req_i.valid;
    assign offset  = reg_req_i.addr[4:0];
    assign status  = {8'h00, 8'(rxCount_q), 8'(txCount_q), 4'h0, rxEmpty, rxFull, txEmpty, txFull};
    assign unusedBits = ^{reg_req_i.wstrb, reg_req_i.addr[31:5]};

    always_comb begin
        busTxPush = 1'b0;
        busRxPop  = 1'b0;
        flushTx   = 1'b0;
        flushRx   = 1'b0;
        accRdata  = '0;
        accError  = 1'b0;
        irqEn_d   = irqEn_q;
        if (access) begin
            if (offset[1:0] != 2'b00) begin
                accError = 1'b1;
            end else begin
                case (offset)
                    5'h00: begin
                        if (!reg_req_i.write || txFull) accError = 1'b1;
                        else                            busTxPush = 1'b1;
                    end
                    5'h04: begin
                        if (reg_req_i.write || rxEmpty) begin
                            accError = 1'b1;
                        end else begin
                            busRxPop = 1'b1;
                            accRdata = rxMem_q[rxRptr_q];
                        end
                    end
                    5'h08: begin
                        if (!reg_req_i.write) accRdata = status;
                    end
                    5'h0C: begin
                        if (reg_req_i.write) irqEn_d  = reg_req_i.wdata[1:0];
                        else                 accRdata = {30'b0, irqEn_q};
                    end
                    5'h10: begin
                        if (reg_req_i.write) begin
                            flushTx = reg_req_i.wdata[0];
                            flushRx = reg_req_i.wdata[1];
                        end
                    end
                    default: accError = 1'b1;
                endcase
            end
        end
    end

    // RX must refuse a producer word in the very cycle software flushes RX, otherwise it would be lost.
    assign tx_valid_o = !txEmpty;
    assign tx_data_o  = txMem_q[txRptr_q];
    assign rx_ready_o = !rst_i && !rxFull && !flushRx;
    assign hwTxPop    = !txEmpty && tx_ready_i;
    assign hwRxPush   = rx_valid_i && rx_ready_o;

    always_comb begin
        txWptr_d  = txWptr_q;
        txRptr_d  = txRptr_q;
        txCount_d = txCount_q;
        rxWptr_d  = rxWptr_q;
        rxRptr_d  = rxRptr_q;
        rxCount_d = rxCount_q;
        if (flushTx) begin
            txRptr_d  = txWptr_q;
            txCount_d = '0;
        end else begin
            if (busTxPush) txWptr_d = txWptr_q + AW'(1);
            if (hwTxPop)   txRptr_d = txRptr_q + AW'(1);
            if (busTxPush && !hwTxPop)      txCount_d = txCount_q + CW'(1);
            else if (!busTxPush && hwTxPop) txCount_d = txCount_q - CW'(1);
        end
        if (flushRx) begin
            rxRptr_d  = rxWptr_q;
            rxCount_d = '0;
        end else begin
            if (hwRxPush) rxWptr_d = rxWptr_q + AW'(1);
            if (busRxPop) rxRptr_d = rxRptr_q + AW'(1);
            if (hwRxPush && !busRxPop)      rxCount_d = rxCount_q + CW'(1);
            else if (!hwRxPush && busRxPop) rxCount_d = rxCount_q - CW'(1);
        end
        intr_d = (irqEn_d[0] && (rxCount_d != '0)) || (irqEn_d[1] && (txCount_d == '0));
    end

    always_ff @(posedge clk_i) begin
        if (busTxPush) txMem_q[txWptr_q] <= reg_req_i.wdata;
        if (hwRxPush)  rxMem_q[rxWptr_q] <= rx_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rsp_q     <= '0;
            txWptr_q  <= '0;
            txRptr_q  <= '0;
            txCount_q <= '0;
            rxWptr_q  <= '0;
            rxRptr_q  <= '0;
            rxCount_q <= '0;
            irqEn_q   <= '0;
            intr_q    <= 1'b0;
        end else begin
            txWptr_q  <= txWptr_d;
            txRptr_q  <= txRptr_d;
            txCount_q <= txCount_d;
            rxWptr_q  <= rxWptr_d;
            rxRptr_q  <= rxRptr_d;
            rxCount_q <= rxCount_d;
            irqEn_q   <= irqEn_d;
            intr_q    <= intr_d;
            case (state_q)
                IDLE: begin
                    if (reg_req_i.valid) begin
                        state_q     <= RESP;
                        rsp_q.ready <= 1'b1;
                        rsp_q.rdata <= accRdata;
                        rsp_q.error <= accError;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    rsp_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    rsp_q   <= '0;
                end
            endcase
        end
    end

    assign reg_rsp_o = rsp_q;
    assign intr_o    = intr_q;

endmodule

// File: tb/tb_reg_mailbox_responder.sv
// Self-checking bench for reg_mailbox_responder: directed scenarios plus randomized traffic,
// all compared against a queue-based model of the mailbox register map.

module tb_reg_mailbox_responder;
    import reg_mailbox_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    reg_req_t    req;
    reg_rsp_t    rsp;
    logic [31:0] txData, rxData;
    logic        txValid, txReady, rxValid, rxReady, intr;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] txQ[$];
    logic [31:0] rxQ[$];
    logic [1:0]  irqEn;
    logic [31:0] lastRdata;

    reg_mailbox_responder #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .reg_req_i (req),
        .reg_rsp_o (rsp),
        .tx_data_o (txData),
        .tx_valid_o(txValid),
        .tx_ready_i(txReady),
        .rx_data_i (rxData),
        .rx_valid_i(rxValid),
        .rx_ready_o(rxReady),
        .intr_o    (intr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // STATUS word as software should see it, built from the model queue occupancies.
    function automatic logic [31:0] statusWord();
        int t = txQ.size();
        int r = rxQ.size();
        logic [31:0] s = '0;
        s[0]     = (t == DEPTH);
        s[1]     = (t == 0);
        s[2]     = (r == DEPTH);
        s[3]     = (r == 0);
        s[15:8]  = t[7:0];
        s[23:16] = r[7:0];
        return s;
    endfunction

    function automatic logic expIntr();
        return (irqEn[0] && rxQ.size() > 0) || (irqEn[1] && txQ.size() == 0);
    endfunction

    // One cycle of stimulus starting at a falling edge: an optional bus access plus optional
    // hardware TX pop / RX push in the same cycle. Decisions use occupancy at the start of the cycle.
    task automatic applyStimulus(input string tag, input bit acc, input bit wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit txRdy, input bit rxVld, input logic [31:0] rxDat);
        int          tSize = txQ.size();
        int          rSize = rxQ.size();
        logic [4:0]  off = addr[4:0];
        logic [31:0] expRdata = '0;
        bit          expErr = 0, doTxPush = 0, doRxPop = 0, flushTxNow = 0, flushRxNow = 0;
        bit          doTxPop, doRxPush, irqWrite;

        req.valid = acc;
        req.write = wr;
        req.addr  = addr;
        req.wdata = wdata;
        req.wstrb = 4'($urandom());
        txReady   = txRdy;
        rxValid   = rxVld;
        rxData    = rxDat;

        irqWrite = acc && wr && (off == 5'h0C);
        if (acc) begin
            if (off[1:0] != 2'b00)  expErr = 1;
            else if (off == 5'h00) begin
                if (!wr || tSize == DEPTH) expErr = 1; else doTxPush = 1;
            end else if (off == 5'h04) begin
                if (wr || rSize == 0) expErr = 1;
                else begin doRxPop = 1; expRdata = rxQ[0]; end
            end else if (off == 5'h08) begin
                if (!wr) expRdata = statusWord();
            end else if (off == 5'h0C) begin
                if (!wr) expRdata = {30'b0, irqEn};
            end else if (off == 5'h10) begin
                if (wr) begin flushTxNow = wdata[0]; flushRxNow = wdata[1]; end
            end else expErr = 1;
        end
        doTxPop  = txRdy && tSize > 0;
        doRxPush = rxVld && rSize < DEPTH && !flushRxNow;

        #1;
        checkOutput({tag, ":tx_valid"}, 32'(txValid), 32'(tSize > 0));
        if (tSize > 0) checkOutput({tag, ":tx_data"}, txData, txQ[0]);
        checkOutput({tag, ":rx_ready"}, 32'(rxReady), 32'(rSize < DEPTH && !flushRxNow));

        if (doTxPop)    void'(txQ.pop_front());
        if (doTxPush)   txQ.push_back(wdata);
        if (flushTxNow) txQ.delete();
        if (doRxPop)    void'(rxQ.pop_front());
        if (doRxPush)   rxQ.push_back(rxDat);
        if (flushRxNow) rxQ.delete();
        if (irqWrite)   irqEn = wdata[1:0];

        @(posedge clk);
        @(negedge clk);
        txReady = 1'b0;
        rxValid = 1'b0;
        if (acc) begin
            lastRdata = rsp.rdata;
            checkOutput({tag, ":ready"}, 32'(rsp.ready), 32'd1);
            checkOutput({tag, ":rdata"}, rsp.rdata, expRdata);
            checkOutput({tag, ":error"}, 32'(rsp.error), 32'(expErr));
            if (!irqWrite) checkOutput({tag, ":intr"}, 32'(intr), 32'(expIntr()));
            req.valid = 1'b0;
            @(negedge clk);
            checkOutput({tag, ":idle_ready_error"}, {30'b0, rsp.ready, rsp.error}, 32'd0);
            checkOutput({tag, ":idle_rdata"}, rsp.rdata, 32'd0);
        end
        checkOutput({tag, ":intr_after"}, 32'(intr), 32'(expIntr()));
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        txReady = 1'b0;
        rxValid = 1'b0;
        rxData  = '0;
        irqEn   = 2'b00;

        // Reset held with a pending request: nothing may respond or accept.
        req.valid = 1'b1;
        req.write = 1'b1;
        req.wdata = 32'h55;
        rxValid   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset:ready", 32'(rsp.ready), 32'd0);
            checkOutput("reset:rx_ready", 32'(rxReady), 32'd0);
            checkOutput("reset:intr", 32'(intr), 32'd0);
            checkOutput("reset:tx_valid", 32'(txValid), 32'd0);
        end
        req.valid = 1'b0;
        rxValid   = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        applyStimulus("status_after_reset", 1, 0, 32'h08, 0, 0, 0, 0);
        checkOutput("status_after_reset:value", lastRdata, 32'h0000_000A);

        // Fill TX, overflow it, then drain it in order.
        for (int i = 0; i < 8; i++) applyStimulus("tx_fill", 1, 1, 32'h00, 32'h11 + i, 0, 0, 0);
        applyStimulus("tx_status", 1, 0, 32'h08, 0, 0, 0, 0);
        checkOutput("tx_status:tx_count", (lastRdata >> 8) & 32'hFF, 32'd8);
        applyStimulus("tx_overflow", 1, 1, 32'h00, 32'h99, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain_order", txData, 32'h11 + i);
            applyStimulus("tx_drain", 0, 0, 0, 0, 1, 0, 0);
        end

        // Fill RX from the producer, then read it back plus one underflow read.
        for (int i = 0; i < 9; i++) applyStimulus("rx_fill", 0, 0, 0, 0, 0, 1, 32'hA0 + rxQ.size());
        for (int i = 0; i < 9; i++) begin
            applyStimulus("rx_read", 1, 0, 32'h04, 0, 0, 0, 0);
            checkOutput("rx_read:order", lastRdata, (i < 8) ? 32'hA0 + i : 32'h0);
        end

        // RX-not-empty interrupt follows a single word in and out.
        applyStimulus("irq_en", 1, 1, 32'h0C, 32'h1, 0, 0, 0);
        applyStimulus("irq_push", 0, 0, 0, 0, 0, 1, 32'h77);
        checkOutput("irq_push:intr_high", 32'(intr), 32'd1);
        applyStimulus("irq_pop", 1, 0, 32'h04, 0, 0, 0, 0);
        checkOutput("irq_pop:intr_low", 32'(intr), 32'd0);

        // Full TX with a bus push racing a hardware pop, then flush everything.
        for (int i = 0; i < 8; i++) applyStimulus("tx_refill", 1, 1, 32'h00, $urandom(), 0, 0, 0);
        applyStimulus("tx_race", 1, 1, 32'h00, 32'hDEAD, 1, 0, 0);
        applyStimulus("race_status", 1, 0, 32'h08, 0, 0, 0, 0);
        checkOutput("race_status:tx_count", (lastRdata >> 8) & 32'hFF, 32'd7);
        applyStimulus("rx_race", 1, 0, 32'h04, 0, 0, 1, 32'h5A);
        applyStimulus("flush_vs_push", 1, 1, 32'h10, 32'h3, 1, 1, 32'h5B);
        applyStimulus("flush_status", 1, 0, 32'h08, 0, 0, 0, 0);
        checkOutput("flush_status:value", lastRdata, 32'h0000_000A);

        // Illegal offsets: error, zero data, no side effects.
        applyStimulus("bad_14_rd", 1, 0, 32'h14, 0, 0, 0, 0);
        applyStimulus("bad_14_wr", 1, 1, 32'h14, 32'hFFFF_FFFF, 0, 0, 0);
        applyStimulus("bad_02_rd", 1, 0, 32'h02, 0, 0, 0, 0);
        applyStimulus("bad_02_wr", 1, 1, 32'h02, 32'hFFFF_FFFF, 0, 0, 0);
        applyStimulus("bad_status", 1, 0, 32'h08, 0, 0, 0, 0);

        // Randomized mix of bus accesses and concurrent producer/consumer activity.
        for (int i = 0; i < 150; i++) begin
            int          sel = $urandom_range(0, 9);
            logic [31:0] r = $urandom();
            logic [4:0]  offs;
            bit          wr;
            case (sel)
                0, 1, 2: offs = 5'h00;
                3, 4:    offs = 5'h04;
                5:       offs = 5'h08;
                6:       offs = 5'h0C;
                7:       offs = ($urandom_range(0, 3) == 0) ? 5'h10 : 5'h08;
                8:       offs = 5'h14;
                default: offs = 5'($urandom_range(0, 31));
            endcase
            if (offs == 5'h00)      wr = ($urandom_range(0, 7) != 0);
            else if (offs == 5'h04) wr = ($urandom_range(0, 7) == 0);
            else                    wr = 1'($urandom_range(0, 1));
            applyStimulus("random", ($urandom_range(0, 3) != 0), wr, {r[31:5], offs}, $urandom(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
        end

        // Reset while the response is pending: the response never appears.
        req.valid = 1'b1;
        req.write = 1'b0;
        req.addr  = 32'h08;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_in_resp:ready_now", 32'(rsp.ready), 32'd0);
        @(negedge clk);
        checkOutput("rst_in_resp:ready_neg", 32'(rsp.ready), 32'd0);
        @(negedge clk);
        checkOutput("rst_in_resp:ready_later", 32'(rsp.ready), 32'd0);
        req.valid = 1'b0;
        rst       = 1'b0;
        txQ.delete();
        rxQ.delete();
        irqEn = 2'b00;
        @(negedge clk);
        checkOutput("rst_in_resp:ready_after", 32'(rsp.ready), 32'd0);
        applyStimulus("final_status", 1, 0, 32'h08, 0, 0, 0, 0);
        checkOutput("final_status:value", lastRdata, 32'h0000_000A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
